// File: rtl/muldiv_hilo_pkg.sv
// Shared encodings for the EX-stage HI/LO unit: op codes, FSM states and default width.
package muldiv_hilo_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_MULT_CAP = 3'b001;
  localparam logic [2:0] OP_DIV      = 3'b010;
  localparam logic [2:0] OP_DIVU     = 3'b011;
  localparam logic [2:0] OP_MTHI     = 3'b100;
  localparam logic [2:0] OP_MTLO     = 3'b101;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

endpackage

// File: rtl/muldiv_hilo_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shift in the next dividend bit and keep the difference only when no borrow occurs.
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, divisor_i};
    if (trial_s[WIDTH]) begin
      rem_o = shifted_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// EX-stage HI/LO unit: multiply capture, MTHI/MTLO, and a WIDTH-step restoring divider
// with registered busy/done/div0 status.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic             signed_op_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic s);
    if (s) begin
      cond_neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = v;
    end
  endfunction

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Next-state logic; done/div0 default low so they only ever pulse for one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div0_d      = 1'b0;
    signed_op_s = (op == OP_DIV);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT_CAP: begin
              hi_d   = alu_hi;
              lo_d   = alu_lo;
              done_d = 1'b1;
            end
            OP_MTHI: begin
              hi_d   = x;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = x;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              if (y == {WIDTH{1'b0}}) begin
                lo_d   = {WIDTH{1'b1}};
                hi_d   = x;
                done_d = 1'b1;
                div0_d = 1'b1;
              end else begin
                // Iterate on magnitudes; signs are reapplied in FIX.
                rem_d   = {WIDTH{1'b0}};
                quo_d   = cond_neg(x, signed_op_s & x[WIDTH-1]);
                dvs_d   = cond_neg(y, signed_op_s & y[WIDTH-1]);
                qsign_d = signed_op_s & (x[WIDTH-1] ^ y[WIDTH-1]);
                rsign_d = signed_op_s & x[WIDTH-1];
                cnt_d   = {CW{1'b0}};
                state_d = S_RUN;
                busy_d  = 1'b1;
              end
            end
            default: begin
              done_d = 1'b0;
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      S_RUN: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        lo_d    = cond_neg(quo_q, qsign_q);
        hi_d    = cond_neg(rem_q, rsign_q);
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- EX-stage HI/LO unit sitting directly downstream of the ALU.
- Captures the ALU's 64-bit multiply product into HI/LO in one cycle.
- Performs DIV/DIVU as a 32-iteration restoring divider, replacing the ALU's combinational divide path.
- Executes MTHI/MTLO writes.
- Presents HI/LO to the writeback mux and a busy stall to the hazard logic.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue request; sampled only when busy=0
- op  in  3  000 NOP, 001 MULT_CAP, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
- x  in  WIDTH  operand rs (dividend / MT source)
- y  in  WIDTH  operand rt (divisor)
- alu_lo  in  WIDTH  ALU product low word
- alu_hi  in  WIDTH  ALU product high word
- busy  out  1  divide in progress; pipeline must stall
- done  out  1  one-cycle pulse; HI/LO updated and valid this cycle
- div0  out  1  one-cycle pulse coincident with done when the divisor was zero
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at a clock edge) forces: state IDLE, hi=0, lo=0, busy=0, done=0, div0=0. Reset overrides any in-flight divide; the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MULT_CAP: at the edge, {hi,lo} <= {alu_hi,alu_lo}. done=1 in the next cycle. Stays IDLE.
- IDLE, start=1, op=MTHI or MTLO: at the edge, hi<=x or lo<=x respectively; the other register is unchanged. done=1 in the next cycle.
- IDLE, start=1, op=DIV/DIVU, y!=0:
  - Latch |x|, |y| (DIVU: raw values), quotient sign = x[31]^y[31], remainder sign = x[31]. Signs are 0 for DIVU.
  - Clear the iteration counter. Go to RUN. busy=1 from the next cycle.
- IDLE, start=1, op=DIV/DIVU, y==0: no iteration. Next cycle lo=32'hFFFFFFFF, hi=x, done=1, div0=1. busy never asserts.
- RUN: one restoring step per cycle.
  - Shift {rem,quo} left by 1, trial subtract divisor.
  - If no borrow, keep the difference and set quo[0]=1.
  - After exactly WIDTH steps, go to FIX.
- FIX: apply sign correction (two's-complement negate where the sign is 1).
  - At the edge: lo<=quotient, hi<=remainder, state<=IDLE.
  - busy=0 and done=1 in the following cycle.
- Latency: start edge = E0. busy is high during cycles E0+1 .. E0+33. done and the new hi/lo are visible in cycle E0+34.
- Signed semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (wraps, no trap).
- start while busy=1 is ignored and has no side effects.
- A NOP or illegal op in IDLE leaves all state unchanged; done stays 0.
- done and div0 are registered, never combinational from inputs. hi and lo are driven directly from registers.
- Operands are captured at the start edge. Changes to x, y, alu_* during RUN have no effect.

Decomposition:
- Shared package holds:
  - op encoding constants: OP_NOP, OP_MULT_CAP, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  - state encoding: S_IDLE, S_RUN, S_FIX
  - WIDTH default
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside muldiv_hilo.

Test Plan:
- Reset then MULT_CAP with alu_hi=0x00000001, alu_lo=0x80000000 -> next cycle done=1, hi=0x00000001, lo=0x80000000, busy=0 throughout.
- DIVU x=100, y=7 -> busy high 33 cycles; cycle E0+34: done=1, lo=14, hi=2.
- DIV x=-7 (0xFFFFFFF9), y=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV x=5, y=0 -> next cycle done=1, div0=1, lo=0xFFFFFFFF, hi=5, busy never 1.
- During a DIVU, at cycle E0+10 pulse start with op=MTHI, x=0x1234 -> ignored. Final hi/lo equal the divide result only.
- At cycle E0+15 of a DIV, drive rst_n=0 for one edge -> hi=lo=0, busy=0, done=0. No done pulse afterwards. A new MTLO x=0xA5A5A5A5 is then accepted normally.
